// File: rtl/dsm_modulator_if.sv
// Sample, tick and status signals between the I2S/clock-divider side and the
// second-order delta-sigma modulator.
`timescale 1ns / 1ps

interface dsm_modulator_if;
   logic [31:0] data_l_i;
   logic        data_l_stb_i;
   logic [31:0] data_r_i;
   logic        data_r_stb_i;
   logic        mod_stb_i;
   logic        enable_i;
   logic [1:0]  dsm_out_o;
   logic        running_o;
   logic        overload_o;

   modport master (
      output data_l_i, data_l_stb_i, data_r_i, data_r_stb_i, mod_stb_i, enable_i,
      input  dsm_out_o, running_o, overload_o
   );

   modport slave (
      input  data_l_i, data_l_stb_i, data_r_i, data_r_stb_i, mod_stb_i, enable_i,
      output dsm_out_o, running_o, overload_o
   );
endinterface

// File: rtl/dsm_modulator.sv
// Stereo second-order 1-bit delta-sigma modulator with saturating integrators,
// an IDLE/RUN controller and a watchdog that drops to a zero-mean idle pattern.
`timescale 1ns / 1ps

module dsm_modulator #(
   parameter int IN_W       = 24,
   parameter int INT_W      = 28,
   parameter int WDOG_TICKS = 2048
) (
   input logic            clk_i,
   input logic            rst_ni,
   dsm_modulator_if.slave bus
);

   localparam int EXT_W = INT_W + 2;
   localparam int WD_W  = $clog2(WDOG_TICKS + 1);

   localparam logic signed [EXT_W-1:0] FB_POS  = EXT_W'(64'sd1 <<< (IN_W - 1));
   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (INT_W - 1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX;
   localparam logic [WD_W-1:0]         WD_LAST = WD_W'(WDOG_TICKS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic signed [INT_W-1:0] i1;
      logic signed [INT_W-1:0] i2;
      logic                    q;
      logic                    clip;
   } step_t;

   function automatic logic signed [INT_W-1:0] clamp(input logic signed [EXT_W-1:0] v);
      logic signed [EXT_W-1:0] c;
      c = v;
      if (v > SAT_MAX)      c = SAT_MAX;
      else if (v < SAT_MIN) c = SAT_MIN;
      return c[INT_W-1:0];
   endfunction

   // One modulator tick for one channel; i2 deliberately integrates the old i1.
   function automatic step_t dsm_step(input logic signed [IN_W-1:0]  x,
                                      input logic signed [INT_W-1:0] i1,
                                      input logic signed [INT_W-1:0] i2,
                                      input logic                    q);
      logic signed [EXT_W-1:0] fb, s1, s2;
      step_t r;
      fb     = q ? FB_POS : -FB_POS;
      s1     = EXT_W'(i1) + EXT_W'(x) - fb;
      s2     = EXT_W'(i2) + EXT_W'(i1) - fb;
      r.i1   = clamp(s1);
      r.i2   = clamp(s2);
      r.q    = ~r.i2[INT_W-1];
      r.clip = (s1 > SAT_MAX) || (s1 < SAT_MIN) || (s2 > SAT_MAX) || (s2 < SAT_MIN);
      return r;
   endfunction

   state_t                  state;
   logic signed [IN_W-1:0]  x_l, x_r;
   logic                    valid_l, valid_r;
   logic signed [INT_W-1:0] i1_l, i2_l, i1_r, i2_r;
   logic [1:0]              dsm_out;
   logic                    overload;
   logic [WD_W-1:0]         wdog;
   step_t                   step_l, step_r;
   logic                    wdog_expire;

   // NOTE: purely combinational; every output is assigned on every pass, so no latch.
   always_comb begin
      step_l      = dsm_step(x_l, i1_l, i2_l, dsm_out[0]);
      step_r      = dsm_step(x_r, i1_r, i2_r, dsm_out[1]);
      wdog_expire = bus.mod_stb_i && !bus.data_l_stb_i && (wdog == WD_LAST);
   end

   // NOTE: non-blocking assignments, so every right-hand side sees pre-edge state
   // (a tick that coincides with a sample strobe therefore uses the old x).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         x_l      <= '0;
         x_r      <= '0;
         valid_l  <= 1'b0;
         valid_r  <= 1'b0;
         i1_l     <= '0;
         i2_l     <= '0;
         i1_r     <= '0;
         i2_r     <= '0;
         dsm_out  <= 2'b00;
         overload <= 1'b0;
         wdog     <= '0;
      end else begin
         overload <= 1'b0;
         if (bus.data_l_stb_i) begin
            x_l     <= bus.data_l_i[31 -: IN_W];
            valid_l <= 1'b1;
         end
         if (bus.data_r_stb_i) begin
            x_r     <= bus.data_r_i[31 -: IN_W];
            valid_r <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.mod_stb_i) dsm_out <= ~dsm_out;
               if (bus.enable_i && valid_l && valid_r) state <= RUN;
            end
            RUN: begin
               if (bus.mod_stb_i) begin
                  i1_l     <= step_l.i1;
                  i2_l     <= step_l.i2;
                  i1_r     <= step_r.i1;
                  i2_r     <= step_r.i2;
                  dsm_out  <= {step_r.q, step_l.q};
                  overload <= step_l.clip | step_r.clip;
               end
               if (bus.data_l_stb_i)   wdog <= '0;
               else if (bus.mod_stb_i) wdog <= wdog + WD_W'(1);

               // NOTE: the last assignment in the block wins, so this exit clear
               // overrides the tick update and any sample-strobe valid set above.
               if (!bus.enable_i || wdog_expire) begin
                  state   <= IDLE;
                  i1_l    <= '0;
                  i2_l    <= '0;
                  i1_r    <= '0;
                  i2_r    <= '0;
                  wdog    <= '0;
                  valid_l <= 1'b0;
                  valid_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dsm_out_o  = dsm_out;
   assign bus.running_o  = (state == RUN);
   assign bus.overload_o = overload;

endmodule
